// File: rtl/prio_pkg.sv
// Shared constants, state encoding and code-classification helpers for the
// priority-encoder code stream (encoder and decoder sides).
package prio_pkg;

    localparam int CODE_W = 8;
    localparam int IDX_W  = 4;
    localparam int VEC_W  = 16;

    localparam logic [CODE_W-1:0] IDLE_CODE_DEFAULT = 8'hF0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CLS_BIT     = 2'd0,
        CLS_NOREQ   = 2'd1,
        CLS_ILLEGAL = 2'd2
    } code_class_e;

    // Bit indices win over the idle encoding should the two ever overlap.
    function automatic code_class_e classify(input logic [CODE_W-1:0] code,
                                             input logic [CODE_W-1:0] idle_code);
        if (code < CODE_W'(VEC_W)) begin
            return CLS_BIT;
        end else if (code == idle_code) begin
            return CLS_NOREQ;
        end else begin
            return CLS_ILLEGAL;
        end
    endfunction

    function automatic logic [VEC_W-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        return VEC_W'(1) << idx;
    endfunction

    // Bits 0..idx set, i.e. (1 << (idx+1)) - 1 without needing a wider result.
    function automatic logic [VEC_W-1:0] to_thermo(input logic [IDX_W-1:0] idx);
        return {VEC_W{1'b1}} >> (IDX_W'(VEC_W - 1) - idx);
    endfunction

endpackage

// File: rtl/prio_code_fifo.sv
// Synchronous show-ahead FIFO of DEPTH encoded codes; DEPTH must be a power of 2
// so the pointers wrap by natural overflow.
module prio_code_fifo
    import prio_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [CODE_W-1:0] din,
    input  logic              pop,
    output logic [CODE_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q gates every read, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_W'(DEPTH));

    a_push_gated : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full));

endmodule

// File: rtl/priority_decoder.sv
// Sink side of the code stream: FIFO-buffered codes replayed as registered one-hot
// vectors for HOLD_CYCLES each. Define PRIO_DEC_THERMO_EN to add out_thermo.
module priority_decoder
    import prio_pkg::*;
#(
    parameter int                DEPTH       = 4,
    parameter int                HOLD_CYCLES = 2,
    parameter logic [CODE_W-1:0] IDLE_CODE   = IDLE_CODE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CODE_W-1:0]          in_code,
    output logic [VEC_W-1:0]           out_onehot,
    output logic                       out_valid,
    output logic                       out_idle,
    output logic                       err,
`ifdef PRIO_DEC_THERMO_EN
    output logic [VEC_W-1:0]           out_thermo,
`endif
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic              fifo_push;
    logic              fifo_pop;
    logic [CODE_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;

    state_e            state_q, state_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic [VEC_W-1:0]  onehot_q, onehot_d;
    logic              valid_q, valid_d;
    logic              idle_q, idle_d;
    logic              err_q, err_d;
`ifdef PRIO_DEC_THERMO_EN
    logic [VEC_W-1:0]  thermo_q, thermo_d;
`endif

    logic              load;
    code_class_e       head_cls;

    assign in_ready  = rst_n && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign head_cls  = classify(fifo_head, IDLE_CODE);

    prio_code_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (in_code),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // A new code is taken whenever the outputs are free: in IDLE, or when the
    // hold counter has expired, which gives back-to-back replay with no gap.
    always_comb begin
        load = 1'b0;
        case (state_q)
            ST_IDLE: load = !fifo_empty;
            ST_HOLD: load = (hold_q == '0) && !fifo_empty;
            default: load = 1'b0;
        endcase
    end

    assign fifo_pop = load;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        idle_d   = idle_q;
        err_d    = 1'b0;
`ifdef PRIO_DEC_THERMO_EN
        thermo_d = thermo_q;
`endif

        if (state_q == ST_HOLD && hold_q != '0) begin
            hold_d = hold_q - HC_W'(1);
        end else if (load) begin
            hold_d = HC_W'(HOLD_CYCLES - 1);
            case (head_cls)
                CLS_BIT: begin
                    state_d  = ST_HOLD;
                    onehot_d = to_onehot(fifo_head[IDX_W-1:0]);
                    valid_d  = 1'b1;
                    idle_d   = 1'b0;
`ifdef PRIO_DEC_THERMO_EN
                    thermo_d = to_thermo(fifo_head[IDX_W-1:0]);
`endif
                end
                CLS_NOREQ: begin
                    state_d  = ST_HOLD;
                    onehot_d = '0;
                    valid_d  = 1'b1;
                    idle_d   = 1'b1;
`ifdef PRIO_DEC_THERMO_EN
                    thermo_d = '0;
`endif
                end
                default: begin
                    state_d  = ST_IDLE;
                    onehot_d = '0;
                    valid_d  = 1'b0;
                    idle_d   = 1'b0;
                    err_d    = 1'b1;
`ifdef PRIO_DEC_THERMO_EN
                    thermo_d = '0;
`endif
                end
            endcase
        end else begin
            // Nothing to present: expired hold with an empty FIFO, or idling.
            state_d  = ST_IDLE;
            onehot_d = '0;
            valid_d  = 1'b0;
            idle_d   = 1'b0;
`ifdef PRIO_DEC_THERMO_EN
            thermo_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            idle_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef PRIO_DEC_THERMO_EN
            thermo_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            idle_q   <= idle_d;
            err_q    <= err_d;
`ifdef PRIO_DEC_THERMO_EN
            thermo_q <= thermo_d;
`endif
        end
    end

    assign out_onehot = onehot_q;
    assign out_valid  = valid_q;
    assign out_idle   = idle_q;
    assign err        = err_q;
    assign fifo_count = fifo_cnt;
`ifdef PRIO_DEC_THERMO_EN
    assign out_thermo = thermo_q;
`endif

    a_err_quiet : assert property (@(posedge clk) disable iff (!rst_n)
        err_q |-> (!valid_q && onehot_q == '0));

    a_idle_implies_valid : assert property (@(posedge clk) disable iff (!rst_n)
        idle_q |-> (valid_q && onehot_q == '0));

endmodule

// File: tb/tb_priority_decoder.sv
// Scoreboard bench for priority_decoder: stimulus queues expected output cycles,
// a negedge monitor pops and compares them whenever the DUT shows valid or err.
module tb_priority_decoder;
    import prio_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_code;
    logic [15:0]      out_onehot;
    logic             out_valid;
    logic             out_idle;
    logic             err;
    logic [2:0]       fifo_count;
`ifdef PRIO_DEC_THERMO_EN
    logic [15:0]      out_thermo;
`endif

    always #5 clk = ~clk;

    priority_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_idle   (out_idle),
        .err        (err),
`ifdef PRIO_DEC_THERMO_EN
        .out_thermo (out_thermo),
`endif
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic [15:0] onehot;
        logic [15:0] thermo;
        logic        idle;
        logic        err;
        bit          contig;   // must directly follow the previous output cycle
        int          exp_cyc;  // absolute cycle it must appear in, -1 = any
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   last_cyc  = -10;
    int   max_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle handshake rules plus scoreboard comparison of outputs.
    always @(negedge clk) begin
        #1;
        if (cyc >= 1) begin
            check("fifo_count_le_depth", 32'(fifo_count <= 3'd4), 32'd1);
            check("in_ready_rule", 32'(in_ready), 32'(rst_n && (fifo_count != 3'd4)));
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
        end
        if (out_valid === 1'b1 || err === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {30'd0, out_valid, err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("out_onehot", 32'(out_onehot), 32'(mon_e.onehot));
                check("out_idle",   32'(out_idle),   32'(mon_e.idle));
                check("err",        32'(err),        32'(mon_e.err));
                check("out_valid",  32'(out_valid),  32'(!mon_e.err));
`ifdef PRIO_DEC_THERMO_EN
                check("out_thermo", 32'(out_thermo), 32'(mon_e.thermo));
`endif
                if (mon_e.contig)       check("no_gap",  32'(cyc), 32'(last_cyc + 1));
                if (mon_e.exp_cyc >= 0) check("latency", 32'(cyc), 32'(mon_e.exp_cyc));
                last_cyc = cyc;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] code, input bit keep,
                        input logic [15:0] exp_oh, input logic [15:0] exp_th,
                        input bit is_idle, input bit is_err, input bit contig, input bit timed);
        exp_t e;
        int   n = 0;
        in_valid = 1'b1;
        in_code  = code;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", 32'(in_ready), 32'd1);
        if (keep) begin
            e.onehot  = is_err ? 16'h0 : exp_oh;
            e.thermo  = is_err ? 16'h0 : exp_th;
            e.idle    = is_idle;
            e.err     = is_err;
            e.contig  = contig;
            e.exp_cyc = timed ? cyc + 2 : -1;
            sb.push_back(e);
            if (!is_err) begin
                e.contig  = 1'b1;
                e.exp_cyc = timed ? cyc + 3 : -1;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid || err) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_onehot"}, 32'(out_onehot), 32'd0);
        check({name, "_valid"},  32'(out_valid),  32'd0);
        check({name, "_idle"},   32'(out_idle),   32'd0);
        check({name, "_err"},    32'(err),        32'd0);
`ifdef PRIO_DEC_THERMO_EN
        check({name, "_thermo"}, 32'(out_thermo), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset held 3 cycles with in_valid asserted; nothing may be stored.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_code  = 8'd5;
        repeat (3) begin
            @(negedge clk);
            check("reset_in_ready", 32'(in_ready), 32'd0);
        end
        check_quiet("reset");
        check("reset_count", 32'(fifo_count), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_count",    32'(fifo_count), 32'd0);
        repeat (4) @(negedge clk);

        // 2: single code with exact latency and hold length.
        send(8'd5, 1'b1, 16'h0020, 16'h003F, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        check_quiet("after_single");

        // 3: back-to-back bit, bit, idle code.
        send(8'd15,  1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'd0,   1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'hF0,  1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();

        // 4: continuous stream of 8 codes fills the FIFO and back-pressures.
        max_count = 0;
        send(8'd1,  1'b1, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'd3,  1'b1, 16'h0008, 16'h000F, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'd6,  1'b1, 16'h0040, 16'h007F, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'd9,  1'b1, 16'h0200, 16'h03FF, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'd10, 1'b1, 16'h0400, 16'h07FF, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'd12, 1'b1, 16'h1000, 16'h1FFF, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'd14, 1'b1, 16'h4000, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'd7,  1'b1, 16'h0080, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        check("fifo_reached_full", 32'(max_count), 32'd4);

        // 5: illegal code from IDLE, then a legal one right behind it.
        send(8'h10, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'd3,  1'b1, 16'h0008, 16'h000F, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        // Illegal code popped at the end of a hold.
        send(8'd2,  1'b1, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hF1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        send(8'd4,  1'b1, 16'h0010, 16'h001F, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        // 6: reset while holding with 3 codes queued behind; they must vanish.
        send(8'd9,  1'b1, 16'h0200, 16'h03FF, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'd11, 1'b1, 16'h0800, 16'h0FFF, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'd13, 1'b0, 16'h2000, 16'h3FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'd8,  1'b0, 16'h0100, 16'h01FF, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'd1,  1'b0, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_reset_count", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("mid_hold_reset");
        check("mid_hold_reset_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_quiet("after_mid_hold_reset");
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
